bypass_writeback_2d: RTL
========================

# bypass_writeback_2d

Writeback-side producer for the 2D-staggered bypass network and physical register file (PRF). It registers per-lane execution results and broadcasts them as bypass packets. It writes the low half of each result into PRF byte-slices 0–1 in the packet cycle, then the high half into slices 2–3 one cycle later. This matches the consumer, which reads the low half in register-read stage 0 and the high half in stage 1. It sits between the execute-lane result buses and the PRF write ports / bypass bus.

## Interface
- ISSUE_WIDTH, 4, number of execution lanes / bypass packets
- SIZE_DATA, 32, result width; must be 4*SRAM_DATA_WIDTH
- SIZE_PHYSICAL_LOG, 7, physical register tag width
- SRAM_DATA_WIDTH, 8, PRF byte-slice width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- result_valid_i  in  ISSUE_WIDTH  per-lane result valid
- result_tag_i  in  ISSUE_WIDTH x SIZE_PHYSICAL_LOG  per-lane destination tag
- result_data_i  in  ISSUE_WIDTH x SIZE_DATA  per-lane result data
- bypassPacket_o  out  bypassPkt [0:ISSUE_WIDTH-1]  per-lane {valid, tag, data} bypass broadcast
- wrLoEn_o  out  ISSUE_WIDTH  write enable for slices 0–1
- wrLoAddr_o  out  ISSUE_WIDTH x SIZE_PHYSICAL_LOG  low-half write address
- wrLoData_o  out  ISSUE_WIDTH x 2*SRAM_DATA_WIDTH  {stage1, stage0} bytes
- wrHiEn_o  out  ISSUE_WIDTH  write enable for slices 2–3
- wrHiAddr_o  out  ISSUE_WIDTH x SIZE_PHYSICAL_LOG  high-half write address
- wrHiData_o  out  ISSUE_WIDTH x 2*SRAM_DATA_WIDTH  {stage3, stage2} bytes
- idle_o  out  1  high when no packet or high-half write is in flight
- dupTagErr_o  out  1  sticky; set when two valid lanes carry the same tag in one cycle

## Operation
- Stage P (packet) register, per lane: captures result_valid_i/tag/data every cycle, with no enable.
  - bypassPacket_o[i] is driven directly from the P register.
  - wrLoEn_o[i] = P.valid; wrLoAddr_o = P.tag; wrLoData_o = P.data[SIZE_DATA/2-1:0].
- Stage H (high) register, per lane: captures P.valid, P.tag and P.data[SIZE_DATA-1:SIZE_DATA/2] every cycle.
  - wrHiEn_o[i] = H.valid; wrHiAddr_o = H.tag; wrHiData_o = H high half.
- Lanes are independent. No lane arbitration; each lane owns its own PRF write port pair.
- Invalid result: packet valid = 0 and both enables = 0 in the corresponding cycles.
- Tag, address and data outputs on invalid lanes hold the last captured values and are don't-care.
- Duplicate detector (combinational on inputs):
  - Any pair i<j with result_valid_i[i] & result_valid_i[j] & equal tags sets dupTagErr_o on the next edge.
  - dupTagErr_o holds until reset.
  - Both lanes are still propagated unchanged; write-port ordering in the PRF is not this block's concern.
- idle_o = ~|P.valid & ~|H.valid.
- No flush input: a low-half write that has issued always completes its high-half write, so no PRF entry is left half-written.

## Timing
- Result sampled at edge T:
  - Packet and low-half write appear in cycle T+1 (latency 1).
  - High-half write appears in cycle T+2 (latency 2).
- Each bypass packet is valid for exactly one cycle per result.
- Consumer correctness contract: the PRF makes a write in cycle C readable from C+1.
  - A reader in stage 0 during T+1 hits the bypass for both halves.
  - A reader in stage 0 during T and stage 1 during T+1 hits via its stage-1 bypass.
  - A reader in stage 0 during T+2 reads the low half from the PRF, then the high half from the PRF in T+3, which was written in T+2.
- Back-to-back results on one lane: accepted every cycle. P and H overlap, so wrLoEn_o and wrHiEn_o can be high together on a lane for different tags.
- Same tag on a lane in consecutive cycles: the new low write in cycle N and the old high write in cycle N coexist. The final PRF contents must equal the newer result after cycle N+1.
- Reset (async): all P/H valids, tags and data clear to 0. Consequently:
  - bypassPacket_o valid = 0, all wr*En_o = 0, all addr/data outputs = 0.
  - idle_o = 1, dupTagErr_o = 0.
- Reset mid-operation drops any pending high-half write; the PRF entry is not guaranteed consistent, which is acceptable because the pipeline is reset too.

## Test plan
- Single result, lane 0, tag 0x15, data 0xDEADBEEF at edge T:
  - T+1: bypassPacket_o[0] = {1, 0x15, 0xDEADBEEF}, wrLoEn_o[0] = 1, wrLoData_o[0] = 0xBEEF.
  - T+2: wrHiEn_o[0] = 1, wrHiAddr_o[0] = 0x15, wrHiData_o[0] = 0xDEAD, packet valid = 0.
  - idle_o returns to 1 at T+3.
- All four lanes valid every cycle for 8 cycles with distinct tags: per lane, every result yields exactly one packet, one low write and one high write, in order; idle_o = 0 throughout and 1 two cycles after the last input.
- Lanes 1 and 3 both valid with tag 0x22 in one cycle: dupTagErr_o = 1 from the next cycle, still 1 after 20 idle cycles; both packets still emitted.
- Lane 2 same tag 0x40 in consecutive cycles with data 0x11112222 then 0x33334444: cycle N shows wrLo 0x4444 alongside wrHi 0x1111; the PRF model ends at 0x33334444.
- Reset asserted asynchronously one cycle after a valid result (between its low and high writes): all outputs go to 0 immediately with no high-half write; idle_o = 1 and dupTagErr_o = 0.
- Consumer co-simulation: instantiate the 2D bypass consumer with a PRF model and issue reads of a just-written tag at each offset T−1…T+3 relative to its packet cycle; data_o equals the full 32-bit result in every case.

Source files
------------

// File: rtl/bypass_writeback_2d.sv
// bypass_writeback_2d
// Writeback-side producer for the 2D-staggered bypass network.
// Each lane registers its execution result once (stage P), broadcasts it
// as a bypass packet and writes the low half into PRF slices 0-1 in that
// same cycle. One cycle later (stage H) the high half goes into slices 2-3,
// which lines up with a consumer that reads the low half in register-read
// stage 0 and the high half in stage 1.
//
// Data width must equal four PRF byte-slices (SIZE_DATA == 4*SRAM_DATA_WIDTH);
// each write port carries two slices.

module bypass_writeback_2d #(
    parameter int ISSUE_WIDTH       = 4,
    parameter int SIZE_DATA         = 32,
    parameter int SIZE_PHYSICAL_LOG = 7,
    parameter int SRAM_DATA_WIDTH   = 8
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic [ISSUE_WIDTH-1:0]             result_valid_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]       result_tag_i   [0:ISSUE_WIDTH-1],
    input  logic [SIZE_DATA-1:0]               result_data_i  [0:ISSUE_WIDTH-1],

    // Packet layout per lane: {valid, tag, data}
    output logic [SIZE_PHYSICAL_LOG+SIZE_DATA:0] bypassPacket_o [0:ISSUE_WIDTH-1],

    output logic [ISSUE_WIDTH-1:0]             wrLoEn_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]       wrLoAddr_o     [0:ISSUE_WIDTH-1],
    output logic [2*SRAM_DATA_WIDTH-1:0]       wrLoData_o     [0:ISSUE_WIDTH-1],

    output logic [ISSUE_WIDTH-1:0]             wrHiEn_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]       wrHiAddr_o     [0:ISSUE_WIDTH-1],
    output logic [2*SRAM_DATA_WIDTH-1:0]       wrHiData_o     [0:ISSUE_WIDTH-1],

    output logic                               idle_o,
    output logic                               dupTagErr_o
);

    localparam int HALF = SIZE_DATA / 2;

    // Stage P: full result as broadcast on the bypass bus
    logic [ISSUE_WIDTH-1:0]       r_pValid;
    logic [SIZE_PHYSICAL_LOG-1:0] r_pTag  [0:ISSUE_WIDTH-1];
    logic [SIZE_DATA-1:0]         r_pData [0:ISSUE_WIDTH-1];

    // Stage H: only the high half is needed one cycle later
    logic [ISSUE_WIDTH-1:0]       r_hValid;
    logic [SIZE_PHYSICAL_LOG-1:0] r_hTag  [0:ISSUE_WIDTH-1];
    logic [HALF-1:0]              r_hData [0:ISSUE_WIDTH-1];

    logic                         r_dupTagErr;
    logic                         w_dupTag;

    // Stage P captures the lane inputs unconditionally every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pValid <= '0;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                r_pTag[i]  <= '0;
                r_pData[i] <= '0;
            end
        end else begin
            r_pValid <= result_valid_i;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                r_pTag[i]  <= result_tag_i[i];
                r_pData[i] <= result_data_i[i];
            end
        end
    end

    // Stage H follows P by one cycle so an issued low write always gets its high write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hValid <= '0;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                r_hTag[i]  <= '0;
                r_hData[i] <= '0;
            end
        end else begin
            r_hValid <= r_pValid;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                r_hTag[i]  <= r_pTag[i];
                r_hData[i] <= r_pData[i][SIZE_DATA-1:HALF];
            end
        end
    end

    // Flag any two valid lanes presenting the same destination tag this cycle
    always_comb begin
        w_dupTag = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            for (int j = i + 1; j < ISSUE_WIDTH; j++) begin
                if (result_valid_i[i] && result_valid_i[j] &&
                    (result_tag_i[i] == result_tag_i[j])) begin
                    w_dupTag = 1'b1;
                end
            end
        end
    end

    // Duplicate-tag error is sticky until reset so software can inspect it later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dupTagErr <= 1'b0;
        end else if (w_dupTag) begin
            r_dupTagErr <= 1'b1;
        end
    end

    // Per-lane outputs come straight off the stage registers
    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
        assign bypassPacket_o[g] = {r_pValid[g], r_pTag[g], r_pData[g]};
        assign wrLoAddr_o[g]     = r_pTag[g];
        assign wrLoData_o[g]     = r_pData[g][HALF-1:0];
        assign wrHiAddr_o[g]     = r_hTag[g];
        assign wrHiData_o[g]     = r_hData[g];
    end

    assign wrLoEn_o    = r_pValid;
    assign wrHiEn_o    = r_hValid;
    assign idle_o      = ~|r_pValid & ~|r_hValid;
    assign dupTagErr_o = r_dupTagErr;

endmodule
